// File: rtl/fifo_reader.sv
// Read-side controller for a registered-output FIFO: pops into a 2-entry skid buffer, delivers on valid/ready.
// Pop-to-valid latency is 2 cycles, and throughput is 1 word/cycle. When ready_in is low, at most 2 words are outstanding.
`timescale 1ns/1ps
module fifo_reader #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              pop,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              idle,
  output logic [CNT_W-1:0]  words_out
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  words_q;
  logic              deq;
  logic [2:0]        occ;

  assign valid_out = (count_q != 2'd0);
  assign deq       = valid_out & ready_in;
  assign data_out  = head_q;
  assign idle      = (state_q == IDLE);
  assign words_out = words_q;

  // Occupancy after this cycle's dequeue, counting the word still in flight.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
  assign pop = (state_q == ACTIVE) & ~fifo_empty & (occ < 3'd2);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({inflight_q, deq})
      2'b10: begin
        if (count_q == 2'd0) head_d = fifo_data;
        else                 tail_d = fifo_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = fifo_data;
        end else begin
          head_d = tail_q;
          tail_d = fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!enable)
          state_d = DRAIN;
        else if (fifo_empty && count_q == 2'd0 && !inflight_q && !pop)
          state_d = IDLE;
      end
      DRAIN: begin
        if (count_q == 2'd0 && !inflight_q) state_d = IDLE;
        else if (enable)                    state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= pop;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (deq) words_q <= words_q + 1'b1;
    end
  end

  // A capture into a full skid without a dequeue would lose a word.
  skid_overflow_a: assert property (@(posedge clk) disable iff (!reset)
    !(inflight_q && !deq && count_q == 2'd2));

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: registered FIFO model, word-order scoreboard, and directed scenarios.
`timescale 1ns/1ps
module tb_fifo_reader;
  localparam int DW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          pop;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          idle;
  logic [CW-1:0] words_out;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .pop(pop), .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .idle(idle), .words_out(words_out)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int delivered = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic          pop_h[64];
  logic          val_h[64];
  logic          idle_h[64];
  logic [DW-1:0] dat_h[64];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One clock cycle: sample at the falling edge, then let the FIFO model respond to the pop.
  task automatic tick();
    logic p;
    @(negedge clk);
    p = pop;
    if (cyc < 64) begin
      pop_h[cyc]  = pop;
      val_h[cyc]  = valid_out;
      idle_h[cyc] = idle;
      dat_h[cyc]  = data_out;
    end
    if (reset && valid_out && ready_in) hs_cnt++;
    @(posedge clk);
    #1;
    if (p && fq.size() > 0) begin
      fifo_data  = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
    end
    chk(idle, name, idle, 1);
    chk(exp_q.size() == 0, {name, "_leftover"}, exp_q.size(), 0);
  endtask

  // Scoreboard: every popped word must come out once, in order; outstanding words never exceed 2.
  logic          prev_vld = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  logic [DW-1:0] exp_w;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      delivered = 0;
      prev_vld  = 1'b0;
      prev_rdy  = 1'b0;
    end else begin
      chk(!(pop && fifo_empty), "pop_while_empty", pop, 0);
      chk(words_out == CW'(delivered), "words_out_track", words_out, CW'(delivered));
      if (prev_vld && !prev_rdy)
        chk(valid_out && data_out == prev_dat, "stall_hold", data_out, prev_dat);
      if (valid_out)
        chk(exp_q.size() > 0, "valid_without_word", valid_out, 0);
      if (valid_out && ready_in && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk(data_out == exp_w, "data_order", data_out, exp_w);
        delivered++;
      end
      if (pop && fq.size() > 0) begin
        exp_q.push_back(fq[0]);
        chk(exp_q.size() <= 2, "outstanding_le2", exp_q.size(), 2);
      end
      prev_vld = valid_out;
      prev_rdy = ready_in;
      prev_dat = data_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npop;
    reset = 1'b0; enable = 1'b0; ready_in = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    #3;
    chk(idle == 1'b1, "rst_idle", idle, 1);
    chk(pop == 1'b0, "rst_pop", pop, 0);
    chk(valid_out == 1'b0, "rst_valid", valid_out, 0);
    chk(words_out == 8'd0, "rst_words", words_out, 0);
    chk(data_out == 12'h000, "rst_data", data_out, 0);
    repeat (2) tick();
    reset = 1'b1;

    // Stream of 5 words with ready held high.
    for (int i = 1; i <= 5; i++) fq.push_back(12'(i));
    fifo_empty = 1'b0; ready_in = 1'b1; enable = 1'b1; cyc = 0;
    repeat (12) tick();
    for (int c = 0; c < 10; c++) begin
      chk(pop_h[c] == (c >= 1 && c <= 5), $sformatf("stream_pop_c%0d", c), pop_h[c], int'(c >= 1 && c <= 5));
      chk(val_h[c] == (c >= 3 && c <= 7), $sformatf("stream_vld_c%0d", c), val_h[c], int'(c >= 3 && c <= 7));
    end
    for (int k = 0; k < 5; k++)
      chk(dat_h[3+k] == 12'(k + 1), $sformatf("stream_dat_%0d", k), dat_h[3+k], k + 1);
    chk(words_out == 8'd5, "stream_words", words_out, 5);
    chk(idle == 1'b1, "stream_idle", idle, 1);

    // Backpressure: 4 words, ready low for 10 cycles.
    ready_in = 1'b0;
    fq.push_back(12'h0A1); fq.push_back(12'h0A2); fq.push_back(12'h0A3); fq.push_back(12'h0A4);
    fifo_empty = 1'b0; cyc = 0;
    repeat (10) tick();
    npop = 0;
    for (int c = 0; c < 10; c++) if (pop_h[c]) npop++;
    chk(npop == 2, "bp_pops", npop, 2);
    chk(valid_out && data_out == 12'h0A1, "bp_hold_head", data_out, 12'h0A1);
    ready_in = 1'b1;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) begin
      chk(val_h[10+k] == 1'b1, $sformatf("bp_vld_%0d", k), val_h[10+k], 1);
      chk(dat_h[10+k] == 12'h0A1 + 12'(k), $sformatf("bp_dat_%0d", k), dat_h[10+k], 12'h0A1 + k);
    end
    chk(val_h[14] == 1'b0, "bp_no_dup", val_h[14], 0);
    chk(words_out == 8'd9, "bp_words", words_out, 9);
    run_until_idle(20, "bp_idle");

    // Drain: drop enable while streaming with one buffered and one in flight.
    for (int i = 0; i < 10; i++) fq.push_back(12'h100 + 12'(i));
    fifo_empty = 1'b0; cyc = 0;
    repeat (4) tick();
    enable = 1'b0;
    repeat (8) tick();
    for (int c = 1; c <= 4; c++) chk(pop_h[c] == 1'b1, $sformatf("drain_pop_c%0d", c), pop_h[c], 1);
    for (int c = 5; c < 12; c++) chk(pop_h[c] == 1'b0, $sformatf("drain_nopop_c%0d", c), pop_h[c], 0);
    for (int k = 0; k < 4; k++)
      chk(val_h[3+k] && dat_h[3+k] == 12'h100 + 12'(k), $sformatf("drain_dat_%0d", k), dat_h[3+k], 12'h100 + k);
    chk(val_h[7] == 1'b0, "drain_vld_end", val_h[7], 0);
    for (int c = 5; c <= 7; c++) chk(idle_h[c] == 1'b0, $sformatf("drain_busy_c%0d", c), idle_h[c], 0);
    chk(idle_h[8] == 1'b1, "drain_idle_c8", idle_h[8], 1);
    chk(fq.size() == 6 && fifo_empty == 1'b0, "drain_fifo_left", fq.size(), 6);
    chk(words_out == 8'd13, "drain_words", words_out, 13);
    enable = 1'b1;
    repeat (3) tick();
    run_until_idle(40, "resume_idle");
    chk(words_out == 8'd19 && fq.size() == 0, "resume_words", words_out, 19);

    // Asynchronous reset mid-stream, checked between edges.
    for (int i = 0; i < 8; i++) fq.push_back(12'h200 + 12'(i));
    fifo_empty = 1'b0; cyc = 0;
    repeat (5) tick();
    #1 reset = 1'b0;
    #1;
    chk(pop == 1'b0, "arst_pop", pop, 0);
    chk(valid_out == 1'b0, "arst_valid", valid_out, 0);
    chk(idle == 1'b1, "arst_idle", idle, 1);
    chk(words_out == 8'd0, "arst_words", words_out, 0);
    chk(data_out == 12'h000, "arst_data", data_out, 0);
    fq.delete(); fifo_empty = 1'b1; fifo_data = '0; enable = 1'b0;
    tick();
    reset = 1'b1;

    // Counter wrap: 257 words with intermittent backpressure.
    for (int i = 0; i < 257; i++) fq.push_back(12'((i * 7 + 3) & 12'hFFF));
    fifo_empty = 1'b0; enable = 1'b1; hs_cnt = 0; cyc = 0;
    for (int n = 0; n < 1500 && !(idle && fq.size() == 0 && n > 3); n++) begin
      ready_in = ((n % 4) != 3);
      tick();
    end
    ready_in = 1'b1;
    chk(idle == 1'b1 && exp_q.size() == 0, "wrap_idle", idle, 1);
    chk(hs_cnt == 257, "wrap_handshakes", hs_cnt, 257);
    chk(words_out == 8'd1, "wrap_words", words_out, 1);

    // Single word: exactly one pop and one handshake.
    fq.push_back(12'h7FF);
    fifo_empty = 1'b0; hs_cnt = 0; cyc = 0;
    repeat (10) tick();
    npop = 0;
    for (int c = 0; c < 10; c++) if (pop_h[c]) npop++;
    chk(npop == 1 && pop_h[1] == 1'b1, "single_pops", npop, 1);
    chk(val_h[3] && dat_h[3] == 12'h7FF, "single_dat", dat_h[3], 12'h7FF);
    chk(hs_cnt == 1, "single_handshakes", hs_cnt, 1);
    chk(idle == 1'b1, "single_idle", idle, 1);
    chk(words_out == 8'd2, "single_words", words_out, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
